// File: rtl/conv_relu_pool.sv
// conv_relu_pool: optional ReLU followed by 2x2/stride-2 max pooling over a row-major result stream.
// One half-row of horizontal maxima is held between the even and odd rows of each pooling band.
module conv_relu_pool #(
   parameter int width    = 32,
   parameter int img_size = 64,
   parameter bit relu_en  = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_start,
   input  logic [width-1:0] result,
   input  logic             result_en,
   output logic [width-1:0] pool_out,
   output logic             pool_en,
   output logic             frame_done,
   output logic             busy
);
   localparam int cw = img_size > 2 ? $clog2(img_size) : 1;
   localparam int bw = img_size > 4 ? $clog2(img_size / 2) : 1;

   logic [cw-1:0] col, row, pos_col, pos_row, ncol, nrow;
   logic [bw-1:0] idx;
   logic signed [width-1:0] v, h_reg, hmax, pmax, buf_rd;
   logic signed [width-1:0] line_buf [2**bw];
   logic last_col, last_row, odd_col, odd_row, fire;

   // frame_start restarts the position so a coincident word lands at (0,0)
   always_comb begin
      pos_col  = frame_start ? '0 : col;
      pos_row  = frame_start ? '0 : row;
      last_col = pos_col == cw'(img_size - 1);
      last_row = pos_row == cw'(img_size - 1);
      odd_col  = pos_col[0];
      odd_row  = pos_row[0];
      idx      = bw'(pos_col >> 1);
      v        = (relu_en && result[width-1]) ? '0 : $signed(result);
      hmax     = (v > h_reg) ? v : h_reg;
      buf_rd   = line_buf[idx];
      pmax     = (buf_rd > hmax) ? buf_rd : hmax;
      fire     = result_en && odd_col && odd_row;
      ncol     = result_en ? (last_col ? '0 : pos_col + 1'b1) : pos_col;
      nrow     = (result_en && last_col) ? (last_row ? '0 : pos_row + 1'b1) : pos_row;
   end

   always_ff @(posedge clk)
      if (result_en && odd_col && !odd_row) line_buf[idx] <= hmax;

   always_ff @(posedge clk)
      if (!rst_n) begin
         col        <= '0;
         row        <= '0;
         h_reg      <= '0;
         pool_out   <= '0;
         pool_en    <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         col        <= ncol;
         row        <= nrow;
         busy       <= (ncol != '0) || (nrow != '0);
         h_reg      <= (result_en && !odd_col) ? v : (frame_start ? '0 : h_reg);
         pool_en    <= fire;
         frame_done <= fire && last_col && last_row;
         if (fire) pool_out <= pmax;
      end
endmodule

// File: tb/tb_conv_relu_pool.sv
// tb_conv_relu_pool: drives 4x4 maps into a ReLU and a pass-through instance and scoreboards both.
// A window-based model queues each pooled word with its due cycle; tables hold hand-derived results.
module tb_conv_relu_pool;
   localparam int MX = 2147483647;
   localparam int MN = -2147483647 - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, frame_start, result_en;
   logic [31:0] result;
   logic [31:0] po1, po0;
   logic        pe1, pe0, fd1, fd0, b1, b0;

   conv_relu_pool #(.width(32), .img_size(4), .relu_en(1'b1)) d1 (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .result(result), .result_en(result_en),
      .pool_out(po1), .pool_en(pe1), .frame_done(fd1), .busy(b1));
   conv_relu_pool #(.width(32), .img_size(4), .relu_en(1'b0)) d0 (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .result(result), .result_en(result_en),
      .pool_out(po0), .pool_en(pe0), .frame_done(fd0), .busy(b0));

   typedef struct { int raw; int relu; bit done; int due; } exp_t;
   typedef struct { int px[16]; int relu[4]; int raw[4]; } map_t;

   exp_t q[$];
   int   got1[$], got0[$];
   map_t tbl[3];
   int   win[4][4];
   int   mr, mc, done_cnt, checks, errors;
   int   cyc = 0;
   bit   busy_next, exp_busy, started;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      exp_busy <= busy_next;
   end

   task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // drive one cycle of inputs and advance the reference model for the word it carries
   task automatic drive(bit rn, bit fs, bit en, int w);
      exp_t e;
      int   m;
      @(posedge clk);
      #1;
      rst_n = rn; frame_start = fs; result_en = en; result = w;
      if (!rn) begin
         mr = 0; mc = 0;
      end else begin
         if (fs) begin
            mr = 0; mc = 0;
         end
         if (en) begin
            win[mr][mc] = w;
            if (mr % 2 == 1 && mc % 2 == 1) begin
               m = win[mr-1][mc-1];
               if (win[mr-1][mc] > m) m = win[mr-1][mc];
               if (win[mr][mc-1] > m) m = win[mr][mc-1];
               if (win[mr][mc] > m) m = win[mr][mc];
               e.raw  = m;
               e.relu = m < 0 ? 0 : m;
               e.done = (mr == 3 && mc == 3);
               e.due  = cyc + 1;
               q.push_back(e);
            end
            mc++;
            if (mc == 4) begin
               mc = 0;
               mr = (mr + 1) % 4;
            end
         end
      end
      busy_next = (mr != 0) || (mc != 0);
   endtask

   always @(negedge clk) if (started) begin : monitor
      exp_t e;
      if (pe1 || pe0) begin
         if (q.size() == 0) chk("unexpected_pool_en", pe1 && pe0, 1'b0);
         else begin
            e = q.pop_front();
            chk("latency", cyc, e.due);
            chk("pool_en_relu", pe1, 1);
            chk("pool_en_raw", pe0, 1);
            chk("pool_out_relu", po1, e.relu);
            chk("pool_out_raw", po0, e.raw);
            chk("frame_done_relu", fd1, e.done);
            chk("frame_done_raw", fd0, e.done);
            got1.push_back(po1);
            got0.push_back(po0);
         end
      end else begin
         if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("missing_pool_en", pe1, 1);
         end
         chk("frame_done_idle", fd1 | fd0, 0);
      end
      if (fd1) done_cnt++;
      chk("busy_relu", b1, exp_busy);
      chk("busy_raw", b0, exp_busy);
   end

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0);
   endtask

   task automatic send_map(int m, int mode);
      for (int i = 0; i < 16; i++) begin
         drive(1, 0, 1, tbl[m].px[i]);
         if (mode == 1) idle(1);
         if (mode == 2) idle($urandom_range(0, 3));
      end
   endtask

   task automatic clear_got();
      got1.delete();
      got0.delete();
      done_cnt = 0;
   endtask

   task automatic check_got(int m, int off);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("map%0d_relu_w%0d", m, k), (off + k < got1.size()) ? got1[off + k] : 32'hDEADBEEF, tbl[m].relu[k]);
         chk($sformatf("map%0d_raw_w%0d", m, k), (off + k < got0.size()) ? got0[off + k] : 32'hDEADBEEF, tbl[m].raw[k]);
      end
   endtask

   initial begin
      tbl[0].px   = '{1, 5, -3, 2, 4, -7, 9, 0, -1, -2, -3, -4, -5, -6, -7, -8};
      tbl[0].relu = '{5, 9, 0, 0};
      tbl[0].raw  = '{5, 9, -1, -3};
      tbl[1].px   = '{MX, MN, 0, -1, MN, MN, -1, -1, MN, MN, 100, -100, MN, MN + 1, -100, 100};
      tbl[1].relu = '{MX, 0, 0, 100};
      tbl[1].raw  = '{MX, 0, MN + 1, 100};
      tbl[2].px   = '{7, 7, -5, -5, 7, 7, -5, -5, 7, 7, -5, -5, 7, 7, -5, -5};
      tbl[2].relu = '{7, 0, 7, 0};
      tbl[2].raw  = '{7, -5, 7, -5};
      rst_n = 1'b0; frame_start = 1'b0; result_en = 1'b0; result = '0;
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      started = 1'b1;
      chk("reset_pool_en", pe1 | pe0, 0);
      chk("reset_pool_out", po1 | po0, 0);
      chk("reset_frame_done", fd1 | fd0, 0);
      chk("reset_busy", b1 | b0, 0);
      // reset in the middle of a map, right after a pooled word was produced
      for (int i = 0; i < 6; i++) drive(1, 0, 1, tbl[0].px[i]);
      drive(0, 0, 1, 123);
      drive(0, 0, 1, -9);
      chk("midreset_pool_out", po1 | po0, 0);
      chk("midreset_pool_en", pe1 | pe0, 0);
      chk("midreset_frame_done", fd1 | fd0, 0);
      chk("midreset_busy", b1 | b0, 0);
      clear_got();
      send_map(0, 0);
      idle(3);
      chk("after_reset_count", got1.size(), 4);
      check_got(0, 0);
      for (int m = 0; m < 3; m++)
         for (int mode = 0; mode < 3; mode++) begin
            clear_got();
            send_map(m, mode);
            idle(3);
            chk($sformatf("map%0d_mode%0d_count", m, mode), got1.size(), 4);
            chk($sformatf("map%0d_mode%0d_done", m, mode), done_cnt, 1);
            check_got(m, 0);
         end
      clear_got();
      send_map(0, 0);
      send_map(1, 0);
      idle(3);
      chk("b2b_count", got1.size(), 8);
      chk("b2b_done", done_cnt, 2);
      check_got(0, 0);
      check_got(1, 4);
      // abandon a map after 6 words with frame_start carrying the next map's first word
      clear_got();
      for (int i = 0; i < 6; i++) drive(1, 0, 1, tbl[1].px[i]);
      drive(1, 1, 1, tbl[0].px[0]);
      for (int i = 1; i < 16; i++) drive(1, 0, 1, tbl[0].px[i]);
      idle(3);
      chk("fs_count", got1.size(), 5);
      chk("fs_done", done_cnt, 1);
      chk("fs_pending_word", got1.size() > 0 ? got1[0] : 32'hDEADBEEF, MX);
      check_got(0, 1);
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
